// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel selectable mux and its arbiter.
package mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_N     = 4;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Index width for n channels; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: grants the first requester after the last winner.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned SEL_W = sel_w(DEFAULT_N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    logic [SEL_W-1:0] idx;

    // Scan last+1 .. last+N modulo N; the first hit wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = SEL_W'((32'(last) + 32'(k)) % N);
            if (!grant_valid && req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_rr_reg.sv
// N-channel valid/ready mux with manual or round-robin select and a one-stage output register.
module mux_n_rr_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned N     = DEFAULT_N,
    localparam int unsigned SEL_W = sel_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_src
);

    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_grant_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;

    rr_arbiter_n #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .last        (last),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    assign load_en = !out_valid || out_ready;

    // Out-of-range sel (non power-of-two N) must never grant.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_grant_valid;
        end else if ((32'(sel) < N) && in_valid[sel]) begin
            grant       = sel;
            grant_valid = 1'b1;
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && grant_valid) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            last      <= SEL_W'(N - 1);
        end else if (load_en && grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant*WIDTH +: WIDTH];
            out_src   <= grant;
            if (mode == MODE_RR) begin
                last <= grant;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_rr_reg.sv
// Directed self-checking bench for mux_n_rr_reg at N=4 and N=3.
module tb_mux_n_rr_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // N=4, WIDTH=16 instance
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;

    // N=3, WIDTH=16 instance
    logic        rst3_n;
    logic [47:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [15:0] out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_src3;

    int n_checks = 0;
    int n_fail   = 0;

    mux_n_rr_reg #(.WIDTH(16), .N(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    mux_n_rr_reg #(.WIDTH(16), .N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_src   (out_src3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {16'h0003, 16'h0002, 16'h0001, 16'hA0A0};
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++;
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        n_checks++;
        if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_src: got %0d expected 0", out_src); end
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL release_in_ready: got %b expected 0001", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 16'hA0A0) begin
            n_fail++;
            $display("FAIL release_first_grant: got v=%0b src=%0d data=%0h expected v=1 src=0 data=a0a0",
                     out_valid, out_src, out_data);
        end
    endtask

    task automatic test_manual();
        mode      = 1'b0;
        sel       = 2'd2;
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        in_data   = {16'h0003, 16'hBEEF, 16'h0001, 16'h0000};
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL manual_in_ready: got %b expected 0100", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL manual_load: got v=%0b src=%0d data=%0h expected v=1 src=2 data=beef",
                     out_valid, out_src, out_data);
        end
        sel = 2'd1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL manual_no_grant_ready: got %b expected 0000", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_src !== 2'd2 || out_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL manual_drain_hold: got v=%0b src=%0d data=%0h expected v=0 src=2 data=beef",
                     out_valid, out_src, out_data);
        end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_src [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        rst_n     = 1'b0;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== exp_src[k] || out_data !== {14'd0, exp_src[k]}) begin
                n_fail++;
                $display("FAIL rr_fair[%0d]: got v=%0b src=%0d data=%0h expected v=1 src=%0d data=%0h",
                         k, out_valid, out_src, out_data, exp_src[k], exp_src[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 16'h0003 || in_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%0b src=%0d data=%0h rdy=%b expected v=1 src=3 data=3 rdy=0000",
                         k, out_valid, out_src, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL unstall_in_ready: got %b expected 0001", in_ready); end
        tick();
        n_checks++;
        if (out_src !== 2'd0 || out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL unstall_grant: got src=%0d data=%0h expected src=0 data=0", out_src, out_data);
        end
    endtask

    task automatic test_sparse_wrap();
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        tick();
        n_checks++;
        if (out_src !== 2'd2) begin n_fail++; $display("FAIL sparse_setup: got src=%0d expected 2", out_src); end
        in_valid = 4'b0011;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL sparse_wrap_ready: got %b expected 0001", in_ready); end
        tick();
        n_checks++;
        if (out_src !== 2'd0 || out_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL sparse_wrap: got src=%0d data=%0h expected src=0 data=0", out_src, out_data);
        end
        tick();
        n_checks++;
        if (out_src !== 2'd1 || out_data !== 16'h0001) begin
            n_fail++;
            $display("FAIL sparse_next: got src=%0d data=%0h expected src=1 data=1", out_src, out_data);
        end
        tick();
        n_checks++;
        if (out_src !== 2'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sparse_again: got src=%0d v=%0b expected src=0 v=1", out_src, out_valid);
        end
    endtask

    task automatic test_odd_n();
        rst3_n     = 1'b1;
        mode3      = 1'b0;
        sel3       = 2'd3;
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        in_data3   = {16'h0222, 16'h0111, 16'h0000};
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL odd_sel3_ready[%0d]: got %b expected 000", k, in_ready3); end
            tick();
            n_checks++;
            if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL odd_sel3_valid[%0d]: got %0b expected 0", k, out_valid3); end
        end
        sel3 = 2'd1;
        tick();
        n_checks++;
        if (out_valid3 !== 1'b1 || out_src3 !== 2'd1 || out_data3 !== 16'h0111) begin
            n_fail++;
            $display("FAIL odd_sel1: got v=%0b src=%0d data=%0h expected v=1 src=1 data=111",
                     out_valid3, out_src3, out_data3);
        end
        out_ready3 = 1'b0;
        tick();
        n_checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== 16'h0111) begin
            n_fail++;
            $display("FAIL odd_stall: got v=%0b data=%0h expected v=1 data=111", out_valid3, out_data3);
        end
        rst3_n = 1'b0;
        tick();
        n_checks++;
        if (out_valid3 !== 1'b0 || in_ready3 !== 3'b000) begin
            n_fail++;
            $display("FAIL odd_reset_midstall: got v=%0b rdy=%b expected v=0 rdy=000", out_valid3, in_ready3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst3_n     = 1'b0;
        mode3      = 1'b0;
        sel3       = 2'd0;
        in_valid3  = 3'b000;
        in_data3   = '0;
        out_ready3 = 1'b0;
        #1;
        test_reset();
        test_manual();
        test_rr_fairness();
        test_backpressure();
        test_sparse_wrap();
        test_odd_n();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
